// File: rtl/truth_table_checker_if.sv
// Bundle of the signals between the truth-table checker and the unit under test.
// The master modport is the checker; the slave modport is the UUT/controller side.
interface truth_table_checker_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            err_valid;
    logic [N_IN-1:0] err_index;
    logic            err_got;

    modport master (
        input  start, dut_out,
        output dut_in, busy, done, pass, err_count, err_valid, err_index, err_got
    );

    modport slave (
        output start, dut_out,
        input  dut_in, busy, done, pass, err_count, err_valid, err_index, err_got
    );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweeper for an N_IN-input, 1-output combinational unit.
// Define STOP_ON_FIRST_ERR_EN to end the sweep at the first mismatching vector.
module truth_table_checker #(
    parameter int                      N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0]    EXPECTED = 8'h5B,
    parameter int                      SETTLE   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    truth_table_checker_if.master     bus
);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'((1 << N_IN) - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FINISH} state_t;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  dut_in_q, dut_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N_IN:0]    err_count_q, err_count_d;
    logic             err_valid_q, err_valid_d;
    logic [N_IN-1:0]  err_index_q, err_index_d;
    logic             err_got_q, err_got_d;

    logic mismatch;
    logic last_vec;
    logic settle_end;

    assign mismatch   = (state_q == S_SAMPLE) && (bus.dut_out != EXPECTED[idx_q]);
    assign last_vec   = (idx_q == LAST_IDX);
    assign settle_end = (cnt_q == CNT_W'(SETTLE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_SETTLE;
            S_SETTLE: if (settle_end) state_d = S_SAMPLE;
            S_SAMPLE: begin
`ifdef STOP_ON_FIRST_ERR_EN
                if (last_vec || mismatch) state_d = S_FINISH;
`else
                if (last_vec) state_d = S_FINISH;
`endif
                else state_d = S_SETTLE;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of every registered output; done/err_valid are single-cycle pulses.
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        dut_in_d    = dut_in_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_valid_d = 1'b0;
        err_index_d = err_index_q;
        err_got_d   = err_got_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dut_in_d    = '0;
                    idx_d       = '0;
                    cnt_d       = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            S_SETTLE: begin
                if (!settle_end) cnt_d = cnt_q + 1'b1;
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_count_d = err_count_q + 1'b1;
                    err_valid_d = 1'b1;
                    err_index_d = idx_q;
                    err_got_d   = bus.dut_out;
                end
                if (state_d == S_SETTLE) begin
                    idx_d    = idx_q + 1'b1;
                    dut_in_d = idx_q + 1'b1;
                    cnt_d    = '0;
                end
            end
            S_FINISH: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                pass_d = (err_count_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            dut_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            err_index_q <= '0;
            err_got_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dut_in_q    <= dut_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_valid_q <= err_valid_d;
            err_index_q <= err_index_d;
            err_got_q   <= err_got_d;
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_index = err_index_q;
    assign bus.err_got   = err_got_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a 3-input instance (default parameters) and a
// 4-input instance, each driving a behavioural UUT, with a queue of expected mismatches.
module tb_truth_table_checker;
    localparam logic [7:0]  EXP3 = 8'h5B;
    localparam logic [15:0] EXP4 = 16'h8000;

    typedef struct {
        int idx;
        bit got;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_r = 1'b0;
    int   sel = 0;
    int   mode3 = 0;
    int   mode4 = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  q3[$];
    ev_t  q4[$];

    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(3)) bus3 ();
    truth_table_checker_if #(.N_IN(4)) bus4 ();

    truth_table_checker #(.N_IN(3), .EXPECTED(8'h5B), .SETTLE(2)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );
    truth_table_checker #(.N_IN(4), .EXPECTED(16'h8000), .SETTLE(1)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    // mode 0: reference function, 1: inverted, 2: vector 5 stuck at 1
    function automatic logic uut3(input logic [2:0] v, input int mode);
        logic a, b, c, f;
        {a, b, c} = v;
        f = (~a & b & c) | (~b & ((a & ~c) | (~a & c))) | (((a & b & ~c) | (~a & ~b)) & ~c);
        if (mode == 1) f = ~f;
        else if (mode == 2 && v == 3'd5) f = 1'b1;
        return f;
    endfunction

    // mode 0: AND4, otherwise OR4
    function automatic logic uut4(input logic [3:0] v, input int mode);
        return (mode == 0) ? (&v) : (|v);
    endfunction

    assign bus3.dut_out = uut3(bus3.dut_in, mode3);
    assign bus4.dut_out = uut4(bus4.dut_in, mode4);
    assign bus3.start   = start_r & (sel == 0);
    assign bus4.start   = start_r & (sel == 1);

    logic       s_busy, s_done, s_pass, s_err_got, s_err_valid;
    logic [4:0] s_err_count;
    logic [3:0] s_err_index, s_dut_in;
    assign s_busy      = (sel == 0) ? bus3.busy      : bus4.busy;
    assign s_done      = (sel == 0) ? bus3.done      : bus4.done;
    assign s_pass      = (sel == 0) ? bus3.pass      : bus4.pass;
    assign s_err_got   = (sel == 0) ? bus3.err_got   : bus4.err_got;
    assign s_err_valid = (sel == 0) ? bus3.err_valid : bus4.err_valid;
    assign s_err_count = (sel == 0) ? {1'b0, bus3.err_count} : bus4.err_count;
    assign s_err_index = (sel == 0) ? {1'b0, bus3.err_index} : bus4.err_index;
    assign s_dut_in    = (sel == 0) ? {1'b0, bus3.dut_in}    : bus4.dut_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every err_valid pulse must match the next queued mismatch.
    always @(negedge clk) begin
        ev_t e;
        if (!reset && bus3.err_valid) begin
            check("n3_err_expected", 32'(q3.size() > 0), 1);
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("n3_err_index", bus3.err_index, e.idx);
                check("n3_err_got", bus3.err_got, e.got);
                $display("n3 mismatch event: index %0d got %0d", bus3.err_index, bus3.err_got);
            end
        end
        if (!reset && bus4.err_valid) begin
            check("n4_err_expected", 32'(q4.size() > 0), 1);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("n4_err_index", bus4.err_index, e.idx);
                check("n4_err_got", bus4.err_got, e.got);
                $display("n4 mismatch event: index %0d got %0d", bus4.err_index, bus4.err_got);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, s_busy, 0);
        check({tag, "_done"}, s_done, 0);
        check({tag, "_pass"}, s_pass, 0);
        check({tag, "_err_count"}, s_err_count, 0);
        check({tag, "_err_valid"}, s_err_valid, 0);
        check({tag, "_err_index"}, s_err_index, 0);
        check({tag, "_err_got"}, s_err_got, 0);
        check({tag, "_dut_in"}, s_dut_in, 0);
    endtask

    task automatic sweep(input int which, input int mode, input bit retrig, input string tag);
        int  n, per, errs, nvec, cyc;
        bit  f, e_bit;
        ev_t e;
        logic [31:0] iv;
        n = (which == 0) ? 8 : 16;
        per = (which == 0) ? 3 : 2;
        errs = 0;
        nvec = 0;
        e.idx = 0;
        e.got = 1'b0;
        sel = which;
        if (which == 0) mode3 = mode; else mode4 = mode;
        for (int i = 0; i < n; i++) begin
            iv = i;
            f = (which == 0) ? uut3(iv[2:0], mode) : uut4(iv[3:0], mode);
            e_bit = (which == 0) ? EXP3[i] : EXP4[i];
            nvec++;
            if (f !== e_bit) begin
                e.idx = i;
                e.got = f;
                if (which == 0) q3.push_back(e); else q4.push_back(e);
                errs++;
`ifdef STOP_ON_FIRST_ERR_EN
                break;
`endif
            end
        end
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        check({tag, "_busy_on_start"}, s_busy, 1);
        cyc = 0;
        while (s_done !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            start_r = (retrig && cyc == 10);
        end
        start_r = 1'b0;
        check({tag, "_done_cycle"}, cyc, nvec * per + 1);
        check({tag, "_pass"}, s_pass, (errs == 0));
        check({tag, "_err_count"}, s_err_count, errs);
        check({tag, "_busy_at_done"}, s_busy, 0);
        if (errs > 0) begin
            check({tag, "_last_err_index"}, s_err_index, e.idx);
            check({tag, "_last_err_got"}, s_err_got, e.got);
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_idle_busy"}, s_busy, 0);
        check({tag, "_idle_done"}, s_done, 0);
        check({tag, "_pass_held"}, s_pass, (errs == 0));
        check({tag, "_queue_drained"}, (which == 0) ? q3.size() : q4.size(), 0);
        $display("sweep %s: done after %0d cycles, err_count %0d, pass %0d",
                 tag, cyc, s_err_count, s_pass);
    endtask

    initial begin
        int cyc;
        int done_seen;
        repeat (3) @(posedge clk);
        #1;
        sel = 0;
        #1;
        check_zero("n3_reset");
        sel = 1;
        #1;
        check_zero("n4_reset");
        reset = 1'b0;

        sweep(0, 0, 1'b0, "clean");
        sweep(0, 1, 1'b0, "inverted");
        sweep(0, 2, 1'b0, "v5_stuck");

        // Abort a sweep while vector 3 is settling.
        sel = 0;
        mode3 = 0;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        cyc = 0;
        while (bus3.dut_in !== 3'd3 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("midreset_reach_idx3", bus3.dut_in, 3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midreset");
        reset = 1'b0;
        done_seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus3.done === 1'b1) done_seen++;
        end
        check("midreset_no_done", done_seen, 0);
        $display("mid-sweep reset: outputs cleared, %0d done pulses afterwards", done_seen);
        sweep(0, 0, 1'b0, "after_reset");

        sweep(0, 0, 1'b1, "retrigger");
        sweep(1, 0, 1'b0, "and4");
        sweep(1, 1, 1'b0, "or4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
